iterative_alu: RTL and testbench
================================

ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port command  input  4  operation code, sampled with start.
REQ-006 SHALL have port inputA  input  WIDTH  first operand, sampled with start.
REQ-007 SHALL have port inputB  input  WIDTH  second operand, sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when result/error/carry become valid.
REQ-010 SHALL have port result  output  2*WIDTH  operation result, held until the next accepted start.
REQ-011 SHALL have port carry  output  1  carry-out of add; inverted borrow (1 = no borrow) of sub; 0 otherwise.
REQ-012 SHALL have port error  output  1  overflow, divide-by-zero or illegal command flag, held with result.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on accepted start for mult/div/mod, IDLE->DONE on accepted start for all other commands, CALC->DONE after the final iteration, DONE->IDLE unconditionally.
REQ-014 SHALL accept start only in IDLE, latching command, inputA and inputB on that edge; start while busy is ignored with no effect.
REQ-015 SHALL drive busy high in CALC and DONE, low in IDLE; done high only in DONE.
REQ-016 SHALL decode commands: 0 ground (result 0), 1 add, 2 sub, 3 unsigned mult, 4 unsigned div (quotient), 5 unsigned mod (remainder), 6..15 illegal.
REQ-017 SHALL complete commands 0, 1, 2, 6..15 with done in the cycle after the accepting edge (latency 1).
REQ-018 SHALL compute add/sub as WIDTH-bit two's-complement A+B / A-B, zero-extended into result; error = signed overflow (carry into MSB XOR carry out of MSB).
REQ-019 SHALL compute mult iteratively, one shift-add step per cycle, WIDTH steps, full 2*WIDTH-bit product, done at cycle WIDTH+1 after acceptance, error 0.
REQ-020 SHALL compute div/mod by restoring division, one quotient bit per cycle, WIDTH steps, WIDTH-bit quotient or remainder zero-extended into result, done at cycle WIDTH+1, error 0.
REQ-021 SHALL, for div/mod with inputB = 0, skip CALC, complete at latency 1 with result 0, carry 0, error 1.
REQ-022 SHALL, for illegal commands, complete at latency 1 with result 0, carry 0, error 1.
REQ-023 SHALL update result, carry and error only on the edge entering DONE; they remain stable until the next accepted start's DONE.
REQ-024 SHALL NOT let input changes after the accepting edge affect the operation in progress.
REQ-025 SHALL accept a new start in the cycle after done (back-to-back throughput: one op per latency+1 cycles).

Reset
REQ-026 SHALL, when rst_n is low at a rising edge, enter IDLE and drive busy 0, done 0, result 0, carry 0, error 0, clearing all iteration state.
REQ-027 SHALL abort any in-progress operation on reset with no done pulse; start sampled in the same cycle as active reset is ignored.

Verification (WIDTH=16)
REQ-028 SHALL verify add/sub: A=249, B=69, cmd 1 -> done 1 cycle later, result 318, error 0; cmd 2 -> result 180, carry 1, error 0.
REQ-029 SHALL verify overflow: A=0x7D00, B=0x3E81, cmd 1 -> result 0x0000BB81, error 1; cmd 2 -> result 0x00003E7F, error 0.
REQ-030 SHALL verify mult: 249*69 -> 17181 with done exactly 17 cycles after start; 0xFFFF*0xFFFF -> 0xFFFE0001, error 0.
REQ-031 SHALL verify div/mod: 1000/7 -> 142 and 1000 mod 7 -> 6, each done at cycle 17; 5/0 -> result 0, error 1, done at cycle 1.
REQ-032 SHALL verify protocol: start held high during a mult and operands changed mid-op -> single done, result from original operands; cmd 9 -> result 0, error 1.
REQ-033 SHALL verify reset: rst_n low at cycle 8 of a mult -> busy 0, result 0, no done; next start with 3*4 -> 12.

Source files
------------

// File: rtl/iterative_alu_if.sv
// Purpose: handshake and data bundle between an iterative_alu and its requester.
// Latency: none, wires only.
// Backpressure: the requester watches busy; a start raised while busy is dropped by the ALU.
// Ports (master = requester, slave = ALU):
//   start, command[3:0], inputA, inputB  -> request side, sampled together
//   busy, done, result[2W-1:0], carry, error <- completion side
interface iterative_alu_if #(
   parameter int WIDTH = 16
);
   logic               start;
   logic [3:0]         command;
   logic [WIDTH-1:0]   inputA;
   logic [WIDTH-1:0]   inputB;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] result;
   logic               carry;
   logic               error;

   modport master (
      output start, command, inputA, inputB,
      input  busy, done, result, carry, error
   );

   modport slave (
      input  start, command, inputA, inputB,
      output busy, done, result, carry, error
   );
endinterface

// File: rtl/iterative_alu.sv
// Purpose: multi-cycle ALU: ground/add/sub in one step, mult/div/mod one bit per cycle.
// Latency: done 1 cycle after accept (ground/add/sub/illegal/div-by-0), WIDTH+1 for mult/div/mod.
// Backpressure: busy high from accept through done; start is ignored unless idle.
// Ports: clk, rst_n (synchronous, active-low); bus = iterative_alu_if.slave
//   (start/command/inputA/inputB in; busy/done/result/carry/error out).
module iterative_alu #(
   parameter int WIDTH = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   iterative_alu_if.slave  bus
);

   localparam int CW = 6;
   localparam logic [3:0] CMD_GND = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_MUL = 4'd3;
   localparam logic [3:0] CMD_DIV = 4'd4;
   localparam logic [3:0] CMD_MOD = 4'd5;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state, state_nxt;
   logic [3:0]           cmd_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        count;
   logic [2*WIDTH-1:0]   result_q;
   logic                 carry_q, error_q;

   logic                 is_div, is_iter, last_step;
   logic [WIDTH:0]       add_full, sub_full;
   logic                 add_ovf, sub_ovf;
   logic [WIDTH:0]       psum;
   logic [2*WIDTH-1:0]   mul_next, div_next, step_acc;
   logic [WIDTH:0]       partial;
   logic                 ge;
   logic [WIDTH-1:0]     rem_sub;

   // Division by zero never iterates; it finishes immediately with error.
   assign is_div    = (bus.command == CMD_DIV) || (bus.command == CMD_MOD);
   assign is_iter   = (bus.command == CMD_MUL) || (is_div && (bus.inputB != '0));
   assign last_step = (count == CW'(WIDTH - 1));

   // Single-cycle ops read the live operands: they retire on the accepting edge.
   assign add_full = {1'b0, bus.inputA} + {1'b0, bus.inputB};
   assign sub_full = {1'b0, bus.inputA} + {1'b0, ~bus.inputB} + (WIDTH+1)'(1);
   assign add_ovf  = (bus.inputA[WIDTH-1] == bus.inputB[WIDTH-1]) &&
                     (add_full[WIDTH-1] != bus.inputA[WIDTH-1]);
   assign sub_ovf  = (bus.inputA[WIDTH-1] != bus.inputB[WIDTH-1]) &&
                     (sub_full[WIDTH-1] != bus.inputA[WIDTH-1]);

   // Shift-add multiply: acc = {partial product, remaining multiplier bits}.
   assign psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
   assign mul_next = {psum, acc[WIDTH-1:1]};

   // Restoring divide: acc = {remainder, dividend bits shifting into quotient}.
   // When the trial subtract succeeds the true difference is below b_q, so the
   // low WIDTH bits of the modular subtraction are exact.
   assign partial  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign ge       = partial >= {1'b0, b_q};
   assign rem_sub  = partial[WIDTH-1:0] - b_q;
   assign div_next = ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                        : {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

   assign step_acc = (cmd_q == CMD_MUL) ? mul_next : div_next;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = is_iter ? CALC : DONE;
         CALC:    if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         count    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               cmd_q <= bus.command;
               a_q   <= bus.inputA;
               b_q   <= bus.inputB;
               count <= '0;
               if (bus.command == CMD_MUL) acc <= {{WIDTH{1'b0}}, bus.inputB};
               else                        acc <= {{WIDTH{1'b0}}, bus.inputA};
               if (!is_iter) begin
                  result_q <= '0;
                  carry_q  <= 1'b0;
                  error_q  <= 1'b0;
                  case (bus.command)
                     CMD_GND: ;
                     CMD_ADD: begin
                        result_q <= {{WIDTH{1'b0}}, add_full[WIDTH-1:0]};
                        carry_q  <= add_full[WIDTH];
                        error_q  <= add_ovf;
                     end
                     CMD_SUB: begin
                        result_q <= {{WIDTH{1'b0}}, sub_full[WIDTH-1:0]};
                        carry_q  <= sub_full[WIDTH];
                        error_q  <= sub_ovf;
                     end
                     default: error_q <= 1'b1;   // div/mod by zero, illegal opcodes
                  endcase
               end
            end
            CALC: begin
               acc   <= step_acc;
               count <= count + CW'(1);
               if (last_step) begin
                  carry_q <= 1'b0;
                  error_q <= 1'b0;
                  case (cmd_q)
                     CMD_MUL: result_q <= step_acc;
                     CMD_MOD: result_q <= {{WIDTH{1'b0}}, step_acc[2*WIDTH-1:WIDTH]};
                     default: result_q <= {{WIDTH{1'b0}}, step_acc[WIDTH-1:0]};
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == DONE);
   assign bus.result = result_q;
   assign bus.carry  = carry_q;
   assign bus.error  = error_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Purpose: self-checking bench for iterative_alu (WIDTH=16), directed plus random ops.
// Latency: checks done timing against 1 / WIDTH+1 cycles from the start cycle.
// Backpressure: issues back-to-back ops and holds start through a busy mult.
module tb_iterative_alu;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   iterative_alu_if #(.WIDTH(W)) bus ();
   iterative_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int passed = 0;
   int failed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour from plain integer arithmetic.
   function automatic void model(input int cmd, input longint a, input longint b,
                                 output longint r, output bit c, output bit e, output int lat);
      longint sa, sb, s;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      r = 0; c = 0; e = 0; lat = 1;
      case (cmd)
         0: ;
         1: begin
            s = a + b; r = s % 65536; c = (s >= 65536);
            e = ((sa + sb) > 32767) || ((sa + sb) < -32768);
         end
         2: begin
            r = (a - b + 65536) % 65536; c = (a >= b);
            e = ((sa - sb) > 32767) || ((sa - sb) < -32768);
         end
         3: begin r = a * b; lat = W + 1; end
         4: if (b == 0) e = 1; else begin r = a / b; lat = W + 1; end
         5: if (b == 0) e = 1; else begin r = a % b; lat = W + 1; end
         default: e = 1;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [3:0] cmd, input logic [15:0] a,
                         input logic [15:0] b, output logic [31:0] res);
      longint er; bit ec, ee; int elat; int lat;
      model(int'(cmd), longint'(a), longint'(b), er, ec, ee, elat);
      @(negedge clk);
      bus.start = 1'b1; bus.command = cmd; bus.inputA = a; bus.inputB = b;
      @(negedge clk);
      // Scramble inputs after acceptance; the op must use the latched values.
      bus.start = 1'b0; bus.command = 4'($urandom); bus.inputA = 16'($urandom);
      bus.inputB = 16'($urandom);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      res = bus.result;
      chk({tag, " latency"}, 64'(lat), 64'(elat));
      chk({tag, " busy@done"}, 64'(bus.busy), 64'(1));
      chk({tag, " result"}, 64'(bus.result), 64'(er));
      chk({tag, " carry"}, 64'(bus.carry), 64'(ec));
      chk({tag, " error"}, 64'(bus.error), 64'(ee));
      @(negedge clk);
      chk({tag, " done pulse"}, 64'(bus.done), 64'(0));
      chk({tag, " idle busy"}, 64'(bus.busy), 64'(0));
      chk({tag, " result held"}, 64'(bus.result), 64'(er));
   endtask

   initial begin
      logic [31:0] r;
      int dones;
      logic [3:0]  rc;
      logic [15:0] ra, rb;

      rst_n = 1'b0; bus.start = 1'b0; bus.command = '0; bus.inputA = '0; bus.inputB = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", 64'(bus.busy), 64'(0));
      chk("reset done", 64'(bus.done), 64'(0));
      chk("reset result", 64'(bus.result), 64'(0));
      chk("reset carry", 64'(bus.carry), 64'(0));
      chk("reset error", 64'(bus.error), 64'(0));
      rst_n = 1'b1;

      run_op("add", 4'd1, 16'd249, 16'd69, r);        chk("add const", 64'(r), 64'd318);
      run_op("sub", 4'd2, 16'd249, 16'd69, r);        chk("sub const", 64'(r), 64'd180);
      run_op("add ovf", 4'd1, 16'h7D00, 16'h3E81, r); chk("add ovf const", 64'(r), 64'h0000BB81);
      run_op("sub novf", 4'd2, 16'h7D00, 16'h3E81, r); chk("sub const2", 64'(r), 64'h00003E7F);
      run_op("mul", 4'd3, 16'd249, 16'd69, r);        chk("mul const", 64'(r), 64'd17181);
      run_op("mul max", 4'd3, 16'hFFFF, 16'hFFFF, r); chk("mul max const", 64'(r), 64'hFFFE0001);
      run_op("div", 4'd4, 16'd1000, 16'd7, r);        chk("div const", 64'(r), 64'd142);
      run_op("mod", 4'd5, 16'd1000, 16'd7, r);        chk("mod const", 64'(r), 64'd6);
      run_op("div0", 4'd4, 16'd5, 16'd0, r);
      run_op("illegal", 4'd9, 16'd12, 16'd34, r);
      run_op("ground", 4'd0, 16'd77, 16'd88, r);
      run_op("sub borrow", 4'd2, 16'd3, 16'd10, r);

      // Start held high through a mult with operands changed mid-operation.
      @(negedge clk);
      bus.start = 1'b1; bus.command = 4'd3; bus.inputA = 16'd100; bus.inputB = 16'd200;
      dones = 0; r = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 3) begin bus.inputA = 16'd7; bus.inputB = 16'd9; bus.command = 4'd4; end
         if (bus.done === 1'b1) begin dones++; bus.start = 1'b0; r = bus.result; end
      end
      bus.start = 1'b0;
      chk("held start dones", 64'(dones), 64'd1);
      chk("held start result", 64'(r), 64'd20000);

      // Reset in cycle 8 of a mult, with start asserted alongside reset.
      @(negedge clk);
      bus.start = 1'b1; bus.command = 4'd3; bus.inputA = 16'd1234; bus.inputB = 16'd567;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0; bus.start = 1'b1; bus.command = 4'd1;
      @(negedge clk);
      chk("abort busy", 64'(bus.busy), 64'(0));
      chk("abort done", 64'(bus.done), 64'(0));
      chk("abort result", 64'(bus.result), 64'(0));
      chk("abort error", 64'(bus.error), 64'(0));
      rst_n = 1'b1; bus.start = 1'b0;
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      end
      chk("abort no done", 64'(dones), 64'd0);
      run_op("post reset mul", 4'd3, 16'd3, 16'd4, r); chk("post reset const", 64'(r), 64'd12);

      for (int i = 0; i < 40; i++) begin
         rc = 4'($urandom_range(0, 15));
         ra = 16'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
         run_op("random", rc, ra, rb, r);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
